// File: rtl/mem_pkg.sv
package mem_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACCESS,
    ST_DONE,
    ST_HOLD
  } state_t;

  typedef enum logic {
    OP_RD,
    OP_WR
  } op_t;

  localparam int unsigned MEM_ADDR_W = 9;
  localparam int unsigned MEM_DATA_W = 32;

  localparam string RAM_INIT_FILE = "ram_init.hex";

  typedef logic [MEM_DATA_W-1:0] ram_image_t [0:(1 << MEM_ADDR_W) - 1];

  function automatic ram_image_t ram_init_image();
    ram_image_t img;
    for (int unsigned i = 0; i < (1 << MEM_ADDR_W); i++) begin
      img[i] = '0;
    end
    img[9'h055] = 32'h0000_0034;
    return img;
  endfunction

endpackage

// File: rtl/ram_array.sv
module ram_array
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W = MEM_ADDR_W,
  parameter int unsigned DATA_W = MEM_DATA_W
) (
  input  logic              Clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [0:(1 << ADDR_W) - 1];

`ifdef RAM_INIT_EN
  initial begin
    ram_image_t img;
    img = ram_init_image();
    for (int unsigned i = 0; i < (1 << ADDR_W); i++) begin
      mem[i] = DATA_W'(img[i % (1 << MEM_ADDR_W)]);
    end
  end
`endif

  always_ff @(posedge Clock) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/ram_responder.sv
// Memory-side responder: latched single-word access after WAIT_STATES cycles,
// one-cycle mem_ready/mem_err pulses. RAM_INIT_EN enables RAM preload.
module ram_responder
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W      = MEM_ADDR_W,
    parameter int unsigned DATA_W      = MEM_DATA_W,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic              Clock,
    input  logic              clear,
    input  logic              Read,
    input  logic              Write,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] Mdatain,
    output logic              mem_ready,
    output logic              mem_err,
    output logic              busy
);

    state_t            state;
    state_t            state_next;
    op_t               op_q;
    logic              err_q;
    logic [3:0]        wcnt;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    logic              req;
    logic              conflict;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_rdata;

    assign req      = Read | Write;
    assign conflict = Read & Write;

    // Present the live address while idle so the registered RAM output is
    // already valid at the ACCESS edge even with zero wait states.
    assign ram_addr = (state == ST_IDLE) ? address : addr_q;
    assign ram_we   = (state == ST_ACCESS) && (op_q == OP_WR) && !clear;

    ram_array #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_ram (
        .Clock(Clock),
        .we   (ram_we),
        .addr (ram_addr),
        .wdata(wdata_q),
        .rdata(ram_rdata)
    );

    always_ff @(posedge Clock) begin
        if (clear) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (conflict) begin
                    state_next = ST_DONE;
                end else if (req) begin
                    state_next = (WAIT_STATES == 0) ? ST_ACCESS : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (wcnt <= 4'd1) begin
                    state_next = ST_ACCESS;
                end
            end
            ST_ACCESS: state_next = ST_DONE;
            ST_DONE:   state_next = ST_HOLD;
            ST_HOLD: begin
                if (!req) begin
                    state_next = ST_IDLE;
                end
            end
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (clear) begin
            wcnt    <= '0;
            err_q   <= 1'b0;
            op_q    <= OP_RD;
            addr_q  <= '0;
            wdata_q <= '0;
            Mdatain <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        addr_q  <= address;
                        wdata_q <= wdata;
                        op_q    <= Write ? OP_WR : OP_RD;
                        wcnt    <= 4'(WAIT_STATES);
                        err_q   <= conflict;
                    end
                end
                ST_WAIT: wcnt <= wcnt - 4'd1;
                ST_ACCESS: begin
                    if (op_q == OP_RD) begin
                        Mdatain <= ram_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        busy      = (state != ST_IDLE);
        mem_ready = (state == ST_DONE);
        mem_err   = (state == ST_DONE) && err_q;
    end

endmodule

// File: tb/tb_ram_responder.sv
// Bench for ram_responder: two instances (WAIT_STATES 0 and 1) sharing a clock,
// scoreboard of expected responses compared against observed responses.
module tb_ram_responder;

    logic        Clock = 1'b0;
    logic        clear [2];
    logic        rd    [2];
    logic        wr    [2];
    logic [8:0]  addr  [2];
    logic [31:0] wdat  [2];
    logic [31:0] mdat  [2];
    logic        rdy   [2];
    logic        err   [2];
    logic        busy  [2];

    always #5 Clock = ~Clock;

    ram_responder #(.ADDR_W(9), .DATA_W(32), .WAIT_STATES(0)) dut0 (
        .Clock(Clock), .clear(clear[0]), .Read(rd[0]), .Write(wr[0]),
        .address(addr[0]), .wdata(wdat[0]), .Mdatain(mdat[0]),
        .mem_ready(rdy[0]), .mem_err(err[0]), .busy(busy[0])
    );

    ram_responder #(.ADDR_W(9), .DATA_W(32), .WAIT_STATES(1)) dut1 (
        .Clock(Clock), .clear(clear[1]), .Read(rd[1]), .Write(wr[1]),
        .address(addr[1]), .wdata(wdat[1]), .Mdatain(mdat[1]),
        .mem_ready(rdy[1]), .mem_err(err[1]), .busy(busy[1])
    );

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          lat;
    } exp_t;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          lat;
        int          pulses;
        bit          busy_ok;
        bit          idle_end;
    } obs_t;

    exp_t exp_q[$];
    obs_t obs_q[$];

    logic [31:0] model   [2][512];
    logic [31:0] last_rd [2];

    int tests_run    = 0;
    int tests_failed = 0;

    // Drives one request on instance d and records what the DUT produced.
    task automatic run_req(input int d, input bit r, input bit w,
                           input logic [8:0] a, input logic [31:0] dat,
                           input int hold);
        obs_t o;
        o.data = 'x; o.err = 1'b0; o.lat = -1; o.pulses = 0;
        o.busy_ok = 1'b1; o.idle_end = 1'b0;
        @(negedge Clock);
        rd[d] = r; wr[d] = w; addr[d] = a; wdat[d] = dat;
        for (int k = 1; k <= 40; k++) begin
            @(negedge Clock);
            if (k == 1) begin
                addr[d] = ~a;
                wdat[d] = ~dat;
            end
            if (rdy[d] === 1'b1) begin
                o.pulses++;
                if (o.lat < 0) begin
                    o.lat  = k;
                    o.data = mdat[d];
                    o.err  = err[d];
                end
            end
            if (k < hold && busy[d] !== 1'b1) o.busy_ok = 1'b0;
            if (k == hold) begin
                rd[d] = 1'b0;
                wr[d] = 1'b0;
            end
            if (k > hold && o.lat >= 0 && busy[d] === 1'b0) begin
                o.idle_end = 1'b1;
                break;
            end
        end
        obs_q.push_back(o);
    endtask

    // Computes the expected response from the bench model, then drives it.
    task automatic issue(input int d, input bit r, input bit w,
                         input logic [8:0] a, input logic [31:0] dat,
                         input int hold);
        exp_t e;
        e.err = 1'b0;
        e.lat = d + 2;
        if (r && w) begin
            e.err = 1'b1;
            e.lat = 1;
        end else if (w) begin
            model[d][a] = dat;
        end else begin
            last_rd[d] = model[d][a];
        end
        e.data = last_rd[d];
        exp_q.push_back(e);
        run_req(d, r, w, a, dat, hold);
    endtask

    task automatic test_reset();
        exp_t e;
        obs_t o;
        for (int d = 0; d < 2; d++) begin
            clear[d] = 1'b1; rd[d] = 1'b0; wr[d] = 1'b0;
            addr[d] = '0; wdat[d] = '0; last_rd[d] = '0;
        end
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        for (int d = 0; d < 2; d++) begin
            tests_run += 4;
            if (mdat[d] !== 32'h0) begin tests_failed++; $display("FAIL reset_mdatain[%0d]: got %h want 0", d, mdat[d]); end
            if (rdy[d] !== 1'b0) begin tests_failed++; $display("FAIL reset_ready[%0d]: got %b want 0", d, rdy[d]); end
            if (err[d] !== 1'b0) begin tests_failed++; $display("FAIL reset_err[%0d]: got %b want 0", d, err[d]); end
            if (busy[d] !== 1'b0) begin tests_failed++; $display("FAIL reset_busy[%0d]: got %b want 0", d, busy[d]); end
            clear[d] = 1'b0;
        end

        issue(1, 1'b0, 1'b1, 9'h010, 32'h1111_1111, 1);
        issue(1, 1'b1, 1'b0, 9'h010, 32'h0, 1);

        // Start a write, then hit clear while it is still waiting.
        @(negedge Clock);
        wr[1] = 1'b1; addr[1] = 9'h010; wdat[1] = 32'h2222_2222;
        @(negedge Clock);
        clear[1] = 1'b1; wr[1] = 1'b0;
        repeat (2) @(negedge Clock);
        tests_run += 4;
        if (mdat[1] !== 32'h0) begin tests_failed++; $display("FAIL midwait_clear_mdatain: got %h want 0", mdat[1]); end
        if (rdy[1] !== 1'b0) begin tests_failed++; $display("FAIL midwait_clear_ready: got %b want 0", rdy[1]); end
        if (err[1] !== 1'b0) begin tests_failed++; $display("FAIL midwait_clear_err: got %b want 0", err[1]); end
        if (busy[1] !== 1'b0) begin tests_failed++; $display("FAIL midwait_clear_busy: got %b want 0", busy[1]); end
        clear[1] = 1'b0;
        last_rd[1] = '0;

        issue(1, 1'b1, 1'b0, 9'h010, 32'h0, 1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            tests_run += 4;
            if (o.lat !== e.lat) begin tests_failed++; $display("FAIL reset_latency: got %0d want %0d", o.lat, e.lat); end
            if (o.pulses !== 1) begin tests_failed++; $display("FAIL reset_pulses: got %0d want 1", o.pulses); end
            if (o.data !== e.data) begin tests_failed++; $display("FAIL reset_data: got %h want %h", o.data, e.data); end
            if (o.err !== e.err) begin tests_failed++; $display("FAIL reset_err_flag: got %b want %b", o.err, e.err); end
        end
    endtask

`ifdef RAM_INIT_EN
    task automatic test_preload();
        exp_t e;
        obs_t o;
        model[1][9'h055] = 32'h0000_0034;
        issue(1, 1'b1, 1'b0, 9'h055, 32'h0, 1);
        e = exp_q.pop_front(); o = obs_q.pop_front();
        tests_run += 2;
        if (o.data !== e.data) begin tests_failed++; $display("FAIL preload_data: got %h want %h", o.data, e.data); end
        if (o.lat !== e.lat) begin tests_failed++; $display("FAIL preload_latency: got %0d want %0d", o.lat, e.lat); end
    endtask
`endif

    task automatic test_write_read();
        exp_t e;
        obs_t o;
        issue(1, 1'b0, 1'b1, 9'h055, 32'h0000_00AB, 3);
        issue(1, 1'b1, 1'b0, 9'h055, 32'h0, 1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            tests_run += 4;
            if (o.lat !== e.lat) begin tests_failed++; $display("FAIL wr_rd_latency: got %0d want %0d", o.lat, e.lat); end
            if (o.pulses !== 1) begin tests_failed++; $display("FAIL wr_rd_pulses: got %0d want 1", o.pulses); end
            if (o.data !== e.data) begin tests_failed++; $display("FAIL wr_rd_data: got %h want %h", o.data, e.data); end
            if (o.err !== e.err) begin tests_failed++; $display("FAIL wr_rd_err: got %b want %b", o.err, e.err); end
        end
    endtask

    task automatic test_held_strobe();
        exp_t e;
        obs_t o;
        issue(1, 1'b1, 1'b0, 9'h055, 32'h0, 8);
        e = exp_q.pop_front(); o = obs_q.pop_front();
        tests_run += 5;
        if (o.pulses !== 1) begin tests_failed++; $display("FAIL held_pulses: got %0d want 1", o.pulses); end
        if (o.busy_ok !== 1'b1) begin tests_failed++; $display("FAIL held_busy: got %b want 1", o.busy_ok); end
        if (o.idle_end !== 1'b1) begin tests_failed++; $display("FAIL held_release: got %b want 1", o.idle_end); end
        if (o.data !== e.data) begin tests_failed++; $display("FAIL held_data: got %h want %h", o.data, e.data); end
        if (o.lat !== e.lat) begin tests_failed++; $display("FAIL held_latency: got %0d want %0d", o.lat, e.lat); end
    endtask

    task automatic test_conflict();
        exp_t e;
        obs_t o;
        issue(1, 1'b0, 1'b1, 9'h020, 32'h3333_3333, 1);
        issue(1, 1'b1, 1'b1, 9'h020, 32'hFFFF_FFFF, 1);
        issue(1, 1'b1, 1'b0, 9'h020, 32'h0, 1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            tests_run += 4;
            if (o.lat !== e.lat) begin tests_failed++; $display("FAIL conflict_latency: got %0d want %0d", o.lat, e.lat); end
            if (o.pulses !== 1) begin tests_failed++; $display("FAIL conflict_pulses: got %0d want 1", o.pulses); end
            if (o.data !== e.data) begin tests_failed++; $display("FAIL conflict_data: got %h want %h", o.data, e.data); end
            if (o.err !== e.err) begin tests_failed++; $display("FAIL conflict_err: got %b want %b", o.err, e.err); end
        end
    endtask

    task automatic test_zero_wait();
        exp_t e;
        obs_t o;
        issue(0, 1'b0, 1'b1, 9'h1FF, 32'hDEAD_BEEF, 1);
        issue(0, 1'b0, 1'b1, 9'h000, 32'h0BAD_F00D, 1);
        issue(0, 1'b1, 1'b0, 9'h1FF, 32'h0, 1);
        issue(0, 1'b1, 1'b0, 9'h000, 32'h0, 2);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            tests_run += 4;
            if (o.lat !== e.lat) begin tests_failed++; $display("FAIL zero_wait_latency: got %0d want %0d", o.lat, e.lat); end
            if (o.pulses !== 1) begin tests_failed++; $display("FAIL zero_wait_pulses: got %0d want 1", o.pulses); end
            if (o.data !== e.data) begin tests_failed++; $display("FAIL zero_wait_data: got %h want %h", o.data, e.data); end
            if (o.err !== e.err) begin tests_failed++; $display("FAIL zero_wait_err: got %b want %b", o.err, e.err); end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        obs_t o;
        logic [8:0] addrs [4];
        addrs[0] = 9'h1FE; addrs[1] = 9'h1FF; addrs[2] = 9'h000; addrs[3] = 9'h001;
        for (int unsigned i = 0; i < 4; i++) begin
            issue(0, 1'b0, 1'b1, addrs[i], $urandom, 1);
        end
        for (int unsigned i = 0; i < 12; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                issue(int'(i % 2), 1'b0, 1'b1, 9'h0C0 + 9'(i % 3), $urandom, 1);
            end else begin
                issue(0, 1'b1, 1'b0, addrs[$urandom_range(0, 3)], 32'h0, 1);
            end
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            tests_run += 4;
            if (o.lat !== e.lat) begin tests_failed++; $display("FAIL b2b_latency: got %0d want %0d", o.lat, e.lat); end
            if (o.pulses !== 1) begin tests_failed++; $display("FAIL b2b_pulses: got %0d want 1", o.pulses); end
            if (o.data !== e.data) begin tests_failed++; $display("FAIL b2b_data: got %h want %h", o.data, e.data); end
            if (o.idle_end !== 1'b1) begin tests_failed++; $display("FAIL b2b_idle: got %b want 1", o.idle_end); end
        end
    endtask

    initial begin
        test_reset();
`ifdef RAM_INIT_EN
        test_preload();
`endif
        test_write_read();
        test_held_strobe();
        test_conflict();
        test_zero_wait();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, %0d tests run", tests_run);
        $fatal(1, "watchdog");
    end

endmodule
